axis_dst_fifo: RTL and testbench
================================

Name: axis_dst_fifo

Overview:
- Output-side AXI4-Stream buffer placed directly downstream of the HDC accelerator's M_AXIS result port, feeding the DMA S2MM channel.
- Absorbs DMA backpressure so the accelerator's dst stream can drain without stalling its output period.
- Optional store-and-forward packet mode releases a result packet only once its TLAST word is stored.
- Exposes level and packet-count status for the AXI-Lite register bank.

Parameters:
- DATA_W, 64: stream data width in bits; TSTRB width is DATA_W/8.
- DEPTH, 32: number of entries; power of two, at least 4.
- PKT_MODE, 0: 0 = cut-through, 1 = store-and-forward on TLAST.

Ports:
- AXIS_ACLK  in  1  stream clock.
- AXIS_ARESETN  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous clear of all contents and counters.
- S_AXIS_TVALID  in  1  upstream word valid.
- S_AXIS_TDATA  in  DATA_W  upstream data.
- S_AXIS_TSTRB  in  DATA_W/8  upstream byte strobes; stored with the data.
- S_AXIS_TLAST  in  1  last word of a packet.
- S_AXIS_TREADY  out  1  space available.
- M_AXIS_TVALID  out  1  word available to DMA.
- M_AXIS_TDATA  out  DATA_W  head data.
- M_AXIS_TSTRB  out  DATA_W/8  head strobes.
- M_AXIS_TLAST  out  1  head TLAST.
- M_AXIS_TREADY  in  1  DMA accepts.
- level  out  $clog2(DEPTH)+1  stored word count, 0..DEPTH.
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets stored (TLAST words in the buffer).
- pkt_ovf  out  1  sticky; packet-mode forced release occurred.

Behaviour:
- Reset (AXIS_ARESETN low, asynchronous): pointers, level, pkt_cnt and pkt_ovf clear to 0. S_AXIS_TREADY=0 while reset is asserted and 1 from the first edge after release. M_AXIS_TVALID=0. Stored data is not reset.
- Push occurs when S_AXIS_TVALID & S_AXIS_TREADY. {TLAST, TSTRB, TDATA} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop occurs when M_AXIS_TVALID & M_AXIS_TREADY, and rd_ptr increments modulo DEPTH.
- S_AXIS_TREADY = (level != DEPTH) & ~flush, registered-equivalent.
- When full, a push is refused even if a pop happens in the same cycle. No combinational TREADY path from M to S.
- Head outputs are first-word-fall-through: M_AXIS_TDATA, TSTRB and TLAST reflect entry rd_ptr combinationally from storage. Outputs are held stable while TVALID & ~TREADY.
- Latency, cut-through mode: a word pushed at edge N is presented with TVALID=1 after edge N, i.e. in cycle N+1.
- Cut-through: M_AXIS_TVALID = (level != 0).
- Store-and-forward: M_AXIS_TVALID = (level != 0) & (pkt_cnt != 0 | release). release is set when level == DEPTH and pkt_cnt == 0, which would otherwise deadlock.
  - Setting release also sets pkt_ovf.
  - release clears on the pop of a TLAST word or on flush.
- level update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- pkt_cnt update: +1 on a push with TLAST, -1 on a pop with head TLAST; both in one cycle leaves it unchanged.
- flush is synchronous and has priority over push/pop in the same cycle. It clears pointers, level, pkt_cnt, pkt_ovf and release. M_AXIS_TVALID=0 in the following cycle. A word offered during flush is dropped (TREADY=0).
- Wrap-around is natural pointer rollover; level disambiguates full from empty.
- Counters never underflow or overflow: pop requires level>0 and push requires level<DEPTH.
- The producer asserting TVALID without TREADY is legal; its data is not sampled.

Decomposition:
- Shared package hdc_pkg holds:
  - AXIS_DATA_W = 64
  - AXIS_STRB_W = 8
  - the packed entry struct {last, strb, data}
  - the DST_FIFO_DEPTH default.
- A single sub-module, fifo_mem (register array with write port plus async read at rd_ptr), is natural. The control and counter logic stays in axis_dst_fifo.

Test Plan:
1. Cut-through, M_AXIS_TREADY=1: push 0x1..0x8 with TLAST on 0x8. Output is 0x1..0x8 in order, each one cycle after its push; TLAST only on 0x8; level never exceeds 1.
2. Full: M_AXIS_TREADY=0, push 33 words. The first 32 are accepted; S_AXIS_TREADY=0 from the cycle after the 32nd push; level=32. Raise TREADY: the 33rd word is accepted one cycle after the first pop.
3. Simultaneous push and pop at level=5 for 10 cycles: level stays at 5, data order is preserved, and the pointers wrap past 31 cleanly.
4. PKT_MODE=1: push 3 words without TLAST, then 1 with TLAST. M_AXIS_TVALID stays 0 until the cycle after the TLAST push; pkt_cnt goes 0→1, then 1→0 after the last word is popped.
5. PKT_MODE=1 with a 40-word packet and no TLAST in the first 32: at level=32, TVALID asserts and pkt_ovf=1. Draining releases the words in order, and pkt_ovf stays 1 until flush.
6. flush asserted at level=12, pkt_cnt=2, with a push offered in the same cycle: next cycle level=0, pkt_cnt=0, TVALID=0, the offered word is not stored. Also assert async reset mid-packet: all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: types and defaults shared across the HDC accelerator's stream blocks.
//   AXIS_DATA_W / AXIS_STRB_W : width of the result stream data and its byte strobes.
//   axis_entry_t              : one buffered stream beat, {last, strb, data}.
//   DST_FIFO_DEPTH            : default depth of the output-side stream buffer.
package hdc_pkg;

  localparam int AXIS_DATA_W    = 64;
  localparam int AXIS_STRB_W    = 8;
  localparam int DST_FIFO_DEPTH = 32;

  typedef struct packed {
    logic                   last;
    logic [AXIS_STRB_W-1:0] strb;
    logic [AXIS_DATA_W-1:0] data;
  } axis_entry_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array for axis_dst_fifo.
//   clk   : write clock.
//   we    : write enable; wdata is stored at waddr on the rising edge.
//   raddr : read address; rdata follows it combinationally so the FIFO head
//           can be presented first-word-fall-through.
// Contents are deliberately not reset.
module fifo_mem
  import hdc_pkg::*;
#(
  parameter int WIDTH = AXIS_DATA_W + AXIS_STRB_W + 1,
  parameter int DEPTH = DST_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_dst_fifo.sv
// axis_dst_fifo: AXI4-Stream buffer between the accelerator result port and
// the DMA S2MM channel, with optional store-and-forward on TLAST.
//   AXIS_ACLK / AXIS_ARESETN : stream clock, asynchronous active-low reset.
//   flush                    : synchronous clear of contents and counters.
//   S_AXIS_*                 : upstream (accelerator) slave stream.
//   M_AXIS_*                 : downstream (DMA) master stream, head is FWFT.
//   level                    : stored words, 0..DEPTH.
//   pkt_cnt                  : TLAST words currently stored.
//   pkt_ovf                  : sticky, a full buffer with no complete packet
//                              was force-released in packet mode.
module axis_dst_fifo
  import hdc_pkg::*;
#(
  parameter int DATA_W   = AXIS_DATA_W,
  parameter int DEPTH    = DST_FIFO_DEPTH,
  parameter int PKT_MODE = 0
) (
  input  logic                     AXIS_ACLK,
  input  logic                     AXIS_ARESETN,
  input  logic                     flush,
  input  logic                     S_AXIS_TVALID,
  input  logic [DATA_W-1:0]        S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0]      S_AXIS_TSTRB,
  input  logic                     S_AXIS_TLAST,
  output logic                     S_AXIS_TREADY,
  output logic                     M_AXIS_TVALID,
  output logic [DATA_W-1:0]        M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]      M_AXIS_TSTRB,
  output logic                     M_AXIS_TLAST,
  input  logic                     M_AXIS_TREADY,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_cnt,
  output logic                     pkt_ovf
);

  localparam int STRB_W = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int EW     = DATA_W + STRB_W + 1;

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] level_reg, level_next;
  logic [CW-1:0] pkt_cnt_reg, pkt_cnt_next;
  logic          release_reg, release_next;
  logic          pkt_ovf_reg, pkt_ovf_next;
  logic          ready_en_reg;

  logic          full, empty, force_rel, push, pop, push_last, pop_last;
  logic [EW-1:0] head_entry;

  assign full  = (level_reg == CW'(DEPTH));
  assign empty = (level_reg == '0);

  // Full with no complete packet inside can never drain in packet mode, so
  // the buffer is released as-is.
  assign force_rel = (PKT_MODE != 0) & full & (pkt_cnt_reg == '0);

  // ready_en_reg keeps TREADY low while reset is held and through the edge
  // of release; the rest depends only on registered level, so there is no
  // combinational path from M_AXIS_TREADY.
  assign S_AXIS_TREADY = ready_en_reg & ~full & ~flush;

  generate
    if (PKT_MODE != 0) begin : g_pkt_valid
      assign M_AXIS_TVALID = ~empty & ((pkt_cnt_reg != '0) | release_reg | force_rel);
    end else begin : g_ct_valid
      assign M_AXIS_TVALID = ~empty;
    end
  endgenerate

  assign push      = S_AXIS_TVALID & S_AXIS_TREADY;
  assign pop       = M_AXIS_TVALID & M_AXIS_TREADY;
  assign push_last = push & S_AXIS_TLAST;
  assign pop_last  = pop & M_AXIS_TLAST;

  fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (AXIS_ACLK),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata ({S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA}),
    .raddr (rd_ptr_reg),
    .rdata (head_entry)
  );

  assign M_AXIS_TDATA = head_entry[DATA_W-1:0];
  assign M_AXIS_TSTRB = head_entry[DATA_W +: STRB_W];
  assign M_AXIS_TLAST = head_entry[EW-1];

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    level_next   = level_reg;
    pkt_cnt_next = pkt_cnt_reg;
    release_next = release_reg;
    pkt_ovf_next = pkt_ovf_reg;
    if (flush) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      level_next   = '0;
      pkt_cnt_next = '0;
      release_next = 1'b0;
      pkt_ovf_next = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_next = level_reg + CW'(1);
        2'b01:   level_next = level_reg - CW'(1);
        default: level_next = level_reg;
      endcase
      case ({push_last, pop_last})
        2'b10:   pkt_cnt_next = pkt_cnt_reg + CW'(1);
        2'b01:   pkt_cnt_next = pkt_cnt_reg - CW'(1);
        default: pkt_cnt_next = pkt_cnt_reg;
      endcase
      // force_rel implies no TLAST is stored, so it never coincides with pop_last.
      if (pop_last) begin
        release_next = 1'b0;
      end else if (force_rel) begin
        release_next = 1'b1;
      end
      pkt_ovf_next = pkt_ovf_reg | force_rel;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      pkt_cnt_reg  <= '0;
      release_reg  <= 1'b0;
      pkt_ovf_reg  <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      release_reg  <= release_next;
      pkt_ovf_reg  <= pkt_ovf_next;
      ready_en_reg <= 1'b1;
    end
  end

  assign level   = level_reg;
  assign pkt_cnt = pkt_cnt_reg;
  assign pkt_ovf = pkt_ovf_reg;

endmodule

// File: tb/tb_axis_dst_fifo.sv
// tb_axis_dst_fifo: drives one shared random stream into a cut-through
// instance (index 0) and a store-and-forward instance (index 1) of
// axis_dst_fifo, and compares each against a queue-based reference model.
module tb_axis_dst_fifo;
  import hdc_pkg::*;

  localparam int DW    = 64;
  localparam int SW    = 8;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [SW-1:0] s_strb = '0;

  logic [1:0]          s_ready, m_valid, m_last, pkt_ovf;
  logic [1:0][DW-1:0]  m_data;
  logic [1:0][SW-1:0]  m_strb;
  logic [1:0][CW-1:0]  level, pkt_cnt;

  always #5 clk = ~clk;

  axis_dst_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(0)) u_ct (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .flush(flush),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data), .S_AXIS_TSTRB(s_strb),
    .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready[0]),
    .M_AXIS_TVALID(m_valid[0]), .M_AXIS_TDATA(m_data[0]), .M_AXIS_TSTRB(m_strb[0]),
    .M_AXIS_TLAST(m_last[0]), .M_AXIS_TREADY(m_ready),
    .level(level[0]), .pkt_cnt(pkt_cnt[0]), .pkt_ovf(pkt_ovf[0])
  );

  axis_dst_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(1)) u_sf (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .flush(flush),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data), .S_AXIS_TSTRB(s_strb),
    .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready[1]),
    .M_AXIS_TVALID(m_valid[1]), .M_AXIS_TDATA(m_data[1]), .M_AXIS_TSTRB(m_strb[1]),
    .M_AXIS_TLAST(m_last[1]), .M_AXIS_TREADY(m_ready),
    .level(level[1]), .pkt_cnt(pkt_cnt[1]), .pkt_ovf(pkt_ovf[1])
  );

  // Reference model: the buffer is just an ordered queue of beats.
  axis_entry_t mq[2][$];
  bit          rel[2];
  bit          ovf[2];
  bit          rdy_en[2];
  int          words[2];

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input int d,
                           input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", tag, d, got, exp, $time);
    end
  endtask

  function automatic int lasts(input int d);
    int n = 0;
    for (int i = 0; i < mq[d].size(); i++) if (mq[d][i].last) n++;
    return n;
  endfunction

  function automatic bit exp_ready(input int d);
    return rst_n && rdy_en[d] && (mq[d].size() < DEPTH) && !flush;
  endfunction

  // Packet mode presents data once a whole packet is stored, or when the
  // buffer is full (nothing else could make room), until that burst ends.
  function automatic bit exp_valid(input int d);
    if (mq[d].size() == 0) return 1'b0;
    if (d == 0) return 1'b1;
    return (lasts(d) != 0) || rel[d] || (mq[d].size() == DEPTH);
  endfunction

  task automatic check_dut(input int d);
    check_val("s_tready", d, 64'(s_ready[d]), 64'(exp_ready(d)));
    check_val("m_tvalid", d, 64'(m_valid[d]), 64'(exp_valid(d)));
    check_val("level", d, 64'(level[d]), 64'(mq[d].size()));
    check_val("pkt_cnt", d, 64'(pkt_cnt[d]), 64'(lasts(d)));
    check_val("pkt_ovf", d, 64'(pkt_ovf[d]), 64'(ovf[d]));
    if (exp_valid(d) && m_valid[d]) begin
      check_val("m_tdata", d, m_data[d], mq[d][0].data);
      check_val("m_tstrb", d, 64'(m_strb[d]), 64'(mq[d][0].strb));
      check_val("m_tlast", d, 64'(m_last[d]), 64'(mq[d][0].last));
    end
  endtask

  task automatic step_model(input int d, input bit pu, input bit po);
    axis_entry_t e;
    if (flush) begin
      mq[d].delete();
      rel[d] = 1'b0;
      ovf[d] = 1'b0;
      words[d] = 0;
    end else begin
      if (d == 1 && mq[d].size() == DEPTH && lasts(d) == 0) begin
        rel[d] = 1'b1;
        ovf[d] = 1'b1;
      end
      if (po) begin
        e = mq[d].pop_front();
        words[d]++;
        if (e.last) begin
          rel[d] = 1'b0;
          $display("pkt dut%0d words=%0d level=%0d t=%0t", d, words[d], mq[d].size(), $time);
          words[d] = 0;
        end
      end
      if (pu) begin
        e.last = s_last;
        e.strb = s_strb;
        e.data = s_data;
        mq[d].push_back(e);
      end
    end
    rdy_en[d] = 1'b1;
  endtask

  task automatic run_phase(input int n, input int p_sv, input int p_mr,
                           input int p_last, input int p_fl);
    bit pu[2];
    bit po[2];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      s_valid = ($urandom_range(99) < p_sv);
      s_data  = {$urandom, $urandom};
      s_strb  = 8'($urandom);
      s_last  = ($urandom_range(99) < p_last);
      m_ready = ($urandom_range(99) < p_mr);
      flush   = ($urandom_range(99) < p_fl);
      #1;
      for (int d = 0; d < 2; d++) begin
        check_dut(d);
        pu[d] = exp_ready(d) && s_valid;
        po[d] = exp_valid(d) && m_ready;
      end
      for (int d = 0; d < 2; d++) step_model(d, pu[d], po[d]);
      @(posedge clk);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      rel[d] = 1'b0;
      ovf[d] = 1'b0;
      rdy_en[d] = 1'b0;
      words[d] = 0;
    end
  endtask

  // Assert reset away from any edge, check outputs settle immediately,
  // then release and check TREADY waits for the first edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) rdy_en[d] = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) rdy_en[d] = 1'b1;

    run_phase(60, 100, 100, 12, 0);   // streaming through, consumer always ready
    run_phase(45, 100, 0, 10, 0);     // fill to full under backpressure
    run_phase(50, 30, 100, 10, 0);    // drain
    run_phase(1, 0, 0, 0, 100);       // flush
    run_phase(45, 100, 0, 0, 0);      // long packet fills buffer: forced release
    run_phase(30, 60, 80, 0, 0);      // drain while packet continues
    run_phase(30, 60, 80, 10, 0);     // packet ends, release clears
    run_phase(1, 0, 0, 0, 100);       // flush clears sticky overflow
    run_phase(1500, 60, 60, 15, 3);   // mixed traffic
    async_reset();
    run_phase(300, 70, 50, 10, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
